// File: rtl/fxp_pkg.sv
// Shared sign-magnitude fixed-point definitions.
// Q-format constants, word type and the product helper.
package fxp_pkg;

  localparam int FRAC_BITS       = 11;
  localparam int BITSIZE_DEFAULT = 16;

  typedef logic [BITSIZE_DEFAULT-1:0] fxp_t;

  typedef struct packed {
    logic        ovf;
    logic [31:0] data;
  } fxp_mul_t;

  // Sign-magnitude product of two words of width 'bits'
  // (bits <= 32). The magnitude is truncated and wraps;
  // ovf flags any magnitude bit lost above the result.
  // A zero magnitude always carries a positive sign.
  function automatic fxp_mul_t fxp_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned bits
  );
    logic [63:0] mask;
    logic [63:0] p;
    logic [63:0] mag;
    logic        sgn;
    fxp_mul_t    r;
    mask   = (64'd1 << (bits - 1)) - 64'd1;
    p      = ({32'd0, a} & mask) * ({32'd0, b} & mask);
    mag    = (p >> FRAC_BITS) & mask;
    sgn    = 1'(a >> (bits - 1)) ^ 1'(b >> (bits - 1));
    r.ovf  = |(p >> (FRAC_BITS + bits - 1));
    r.data = mag[31:0]
           | ({31'd0, sgn && (mag != 64'd0)} << (bits - 1));
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// req: lane requests, advance: grant taken, grant: one-hot.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] rr_ptr_d;
  logic [PW-1:0] gidx;
  logic [PW-1:0] kk;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    kk    = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      kk = PW'((int'(rr_ptr_q) + i) % NREQ);
      if (!found && req[kk]) begin
        grant[kk] = 1'b1;
        gidx      = kk;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0
               : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// One pipelined fixed-point multiplier shared by NREQ lanes.
// req_*: per-lane handshake/operands, rsp_*: tagged product.
module mult_share_arbiter
  import fxp_pkg::*;
#(
  parameter int BITSIZE = 16,
  parameter int NREQ    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*BITSIZE-1:0] req_a,
  input  logic [NREQ*BITSIZE-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [NREQ-1:0]         rsp_tag,
  output logic [BITSIZE-1:0]      rsp_data,
  output logic                    rsp_ovf
);

  logic [NREQ-1:0]    grant;
  logic               accept;
  logic               s1_adv;
  logic               s2_adv;
  logic [BITSIZE-1:0] sel_a;
  logic [BITSIZE-1:0] sel_b;
  fxp_mul_t           res;
  logic               unused_hi;

  logic               s1_v_q, s1_v_d;
  logic [BITSIZE-1:0] s1_a_q, s1_a_d;
  logic [BITSIZE-1:0] s1_b_q, s1_b_d;
  logic [NREQ-1:0]    s1_tag_q, s1_tag_d;
  logic               s2_v_q, s2_v_d;
  logic [BITSIZE-1:0] s2_data_q, s2_data_d;
  logic               s2_ovf_q, s2_ovf_d;
  logic [NREQ-1:0]    s2_tag_q, s2_tag_d;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Ready is combinational so a downstream release
  // reopens the input in the same cycle.
  always_comb begin
    s2_adv    = !s2_v_q || rsp_ready;
    s1_adv    = !s1_v_q || s2_adv;
    req_ready = rst ? (grant & {NREQ{s1_adv}}) : '0;
    accept    = |req_ready;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*BITSIZE +: BITSIZE];
        sel_b = req_b[i*BITSIZE +: BITSIZE];
      end
    end
  end

  assign res = fxp_mul(32'(s1_a_q), 32'(s1_b_q),
                       BITSIZE);
  assign unused_hi = ^res.data[31:BITSIZE];

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_tag_d = s1_tag_q;
    if (s1_adv) begin
      s1_v_d = accept;
      if (accept) begin
        s1_a_d   = sel_a;
        s1_b_d   = sel_b;
        s1_tag_d = grant;
      end
    end
  end

  always_comb begin
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_ovf_d  = s2_ovf_q;
    s2_tag_d  = s2_tag_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d = res.data[BITSIZE-1:0];
        s2_ovf_d  = res.ovf;
        s2_tag_d  = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_ovf_q  <= 1'b0;
      s2_tag_q  <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_tag_q  <= s1_tag_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_ovf_q  <= s2_ovf_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

  assign rsp_valid = s2_v_q;
  assign rsp_data  = s2_data_q;
  assign rsp_ovf   = s2_ovf_q;
  assign rsp_tag   = s2_tag_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter.
// Random and directed traffic against a queue-level model.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_tag;
  logic [15:0] rsp_data;
  logic        rsp_ovf;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .BITSIZE (16),
    .NREQ    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] data;
    logic        ovf;
    int          age;
  } item_t;

  item_t sb[$];
  item_t mdl[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    mptr = 0;
  bit    post_rst = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference product from plain arithmetic on the
  // Q4.11 values: scale down, truncate, wrap.
  function automatic void ref_mul(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] d,
    output logic        o
  );
    longint unsigned p;
    longint unsigned q;
    p = longint'(a[14:0]) * longint'(b[14:0]);
    q = p / 2048;
    o = (q >= 32768);
    q = q % 32768;
    d = {(a[15] ^ b[15]) && (q != 0), q[14:0]};
  endfunction

  function automatic logic [63:0] lane(input int l,
                                       input logic [15:0] x);
    logic [63:0] v;
    v = '0;
    v[l*16 +: 16] = x;
    return v;
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [15:0] x;
    x = 16'($urandom);
    if ($urandom_range(0, 1) == 0) x[14:11] = 4'($urandom_range(0, 3));
    return x;
  endfunction

  function automatic logic [63:0] rnd_vec();
    return {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
  endfunction

  task automatic cycle(input logic        r,
                       input logic [3:0]  v,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic        rr);
    logic [3:0]  eg;
    logic        eacc;
    logic        erv;
    logic [15:0] d;
    logic        o;
    int          g;
    item_t       it;
    @(posedge clk);
    #1;
    if (post_rst) begin
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_tag", rsp_tag, 0);
      chk("rst_ovf", rsp_ovf, 0);
    end
    rst = r;
    req_valid = v;
    req_a = a;
    req_b = b;
    rsp_ready = rr;
    eg = '0;
    g = 0;
    for (int k = 0; k < 4; k++) begin
      if (eg == 0 && v[(mptr + k) % 4]) begin
        g = (mptr + k) % 4;
        eg[g] = 1'b1;
      end
    end
    erv = mdl.size() > 0 && mdl[0].age >= 1;
    eacc = r && (eg != 0) && (mdl.size() < 2 || rr);
    @(negedge clk);
    chk("req_ready", req_ready, eacc ? eg : 4'd0);
    chk("rsp_valid", rsp_valid, erv);
    #1;
    if (!r) begin
      mdl.delete();
      sb.delete();
      mptr = 0;
      post_rst = 1;
    end else begin
      post_rst = 0;
      if (erv && rr) void'(mdl.pop_front());
      foreach (mdl[i]) mdl[i].age++;
      if (eacc) begin
        ref_mul(a[g*16 +: 16], b[g*16 +: 16], d, o);
        it = '{tag: eg, data: d, ovf: o, age: 0};
        mdl.push_back(it);
        sb.push_back(it);
        mptr = (g + 1) % 4;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 4'd0, '0, '0, 1);
  endtask

  // Monitor: pops on every response handshake and
  // checks that a stalled response holds still.
  initial begin
    logic        held;
    logic [3:0]  ht;
    logic [15:0] hd;
    logic        ho;
    item_t       e;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", rsp_valid, 1);
          chk("hold_data", rsp_data, hd);
          chk("hold_tag", rsp_tag, ht);
          chk("hold_ovf", rsp_ovf, ho);
        end
        held = 0;
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_extra: got tag %0h expected none",
                     rsp_tag);
          end else begin
            e = sb.pop_front();
            chk("rsp_tag", rsp_tag, e.tag);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_ovf", rsp_ovf, e.ovf);
          end
        end else if (rsp_valid) begin
          held = 1;
          ht = rsp_tag;
          hd = rsp_data;
          ho = rsp_ovf;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 0;
    cycle(0, 4'd0, '0, '0, 0);
    cycle(0, 4'd0, '0, '0, 0);
    // basic, sign, -0 and overflow products
    cycle(1, 4'b0001, lane(0, 16'h0C00), lane(0, 16'h1000), 1);
    idle(3);
    cycle(1, 4'b0100, lane(2, 16'h8C00), lane(2, 16'h1000), 1);
    cycle(1, 4'b0100, lane(2, 16'h8000), lane(2, 16'h1000), 1);
    cycle(1, 4'b0010, lane(1, 16'h4000), lane(1, 16'h1000), 1);
    idle(3);
    // fairness: everyone requesting
    for (int i = 0; i < 8; i++) cycle(1, 4'hF, rnd_vec(), rnd_vec(), 1);
    idle(3);
    // backpressure with lanes 1 and 3
    for (int i = 0; i < 5; i++) cycle(1, 4'b1010, rnd_vec(), rnd_vec(), 0);
    idle(4);
    // reset with both stages full
    for (int i = 0; i < 3; i++) cycle(1, 4'hF, rnd_vec(), rnd_vec(), 0);
    cycle(0, 4'hF, rnd_vec(), rnd_vec(), 0);
    cycle(1, 4'b1000, rnd_vec(), rnd_vec(), 1);
    idle(3);
    // single requester wraps the pointer
    for (int i = 0; i < 6; i++) cycle(1, 4'b0100, rnd_vec(), rnd_vec(), 1);
    idle(3);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) != 0,
            4'($urandom_range(0, 15)),
            rnd_vec(), rnd_vec(),
            $urandom_range(0, 3) != 0);
    end
    // bounded drain
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
